// File: rtl/alu_control_seq_if.sv
// Bundle between the control path and the ALU / mult-div sequencer.
// The master drives the decoded instruction fields; the slave returns OP and sequencing strobes.
interface alu_control_seq_if #(
    parameter int OP_W = 4
) ();
    logic            VALID;
    logic [2:0]      ALUOP;
    logic [5:0]      FUNCTION;
    logic [OP_W-1:0] OP;
    logic            ILLEGAL;
    logic            STALL;
    logic            MD_START;
    logic            MD_DIV;
    logic            HILO_WE;
    logic            BUSY;

    modport master (
        output VALID, ALUOP, FUNCTION,
        input  OP, ILLEGAL, STALL, MD_START, MD_DIV, HILO_WE, BUSY
    );

    modport slave (
        input  VALID, ALUOP, FUNCTION,
        output OP, ILLEGAL, STALL, MD_START, MD_DIV, HILO_WE, BUSY
    );
endinterface

// File: rtl/alu_control_seq.sv
// ALU opcode decoder with a sequencer for the multi-cycle mult/div unit:
// start pulse, pipeline stall while busy, and a one-cycle HI/LO write-enable on completion.
module alu_control_seq #(
    parameter int OP_W        = 4,
    parameter int MULT_CYCLES = 4,
    parameter int DIV_CYCLES  = 8,
    parameter int CNT_W       = $clog2((MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES) + 1
) (
    input logic              CLK,
    input logic              RST,
    alu_control_seq_if.slave bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [3:0] C_ADD  = 4'd0;
    localparam logic [3:0] C_SUB  = 4'd1;
    localparam logic [3:0] C_AND  = 4'd2;
    localparam logic [3:0] C_OR   = 4'd3;
    localparam logic [3:0] C_SLT  = 4'd4;
    localparam logic [3:0] C_XOR  = 4'd5;
    localparam logic [3:0] C_SLL  = 4'd6;
    localparam logic [3:0] C_MULT = 4'd7;
    localparam logic [3:0] C_DIV  = 4'd8;

    localparam logic [5:0] F_MULT = 6'b011000;
    localparam logic [5:0] F_DIV  = 6'b011010;

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OP_W-1:0] r_op;
    logic            r_md_div;

    logic [3:0]      w_dec_code;
    logic            w_dec_legal;
    logic [OP_W-1:0] w_dec_op;
    logic            w_is_md;
    logic            w_is_div;
    logic            w_live;
    logic            w_accept;

    always_comb begin
        w_dec_code  = C_ADD;
        w_dec_legal = 1'b1;
        case (bus.ALUOP)
            3'b000: w_dec_code = C_ADD;
            3'b001: w_dec_code = C_SUB;
            3'b011: w_dec_code = C_AND;
            3'b100: w_dec_code = C_OR;
            3'b101: w_dec_code = C_SLT;
            3'b010: begin
                case (bus.FUNCTION)
                    6'b100000: w_dec_code = C_ADD;
                    6'b100010: w_dec_code = C_SUB;
                    6'b100100: w_dec_code = C_AND;
                    6'b100101: w_dec_code = C_OR;
                    6'b101010: w_dec_code = C_SLT;
                    6'b100110: w_dec_code = C_XOR;
                    6'b010000: w_dec_code = C_SLL;
                    F_MULT:    w_dec_code = C_MULT;
                    F_DIV:     w_dec_code = C_DIV;
                    default:   w_dec_legal = 1'b0;
                endcase
            end
            default: w_dec_legal = 1'b0;
        endcase
    end

    assign w_dec_op = OP_W'(w_dec_code);
    assign w_is_div = (bus.FUNCTION == F_DIV);
    assign w_is_md  = bus.VALID & (bus.ALUOP == 3'b010) &
                      ((bus.FUNCTION == F_MULT) | (bus.FUNCTION == F_DIV));

    // Decode is ignored while the unit is busy; DONE behaves like IDLE so ops can go back-to-back.
    assign w_live   = (r_state != S_BUSY);
    assign w_accept = w_live & w_is_md & ~RST;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_op     <= '0;
            r_md_div <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_state  <= S_BUSY;
                        r_cnt    <= w_is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
                        r_op     <= w_dec_op;
                        r_md_div <= w_is_div;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.OP       = (r_state == S_BUSY) ? r_op : w_dec_op;
    assign bus.ILLEGAL  = w_live & bus.VALID & ~w_dec_legal;
    assign bus.STALL    = ~RST & (w_accept | (r_state == S_BUSY));
    assign bus.MD_START = w_accept;
    assign bus.MD_DIV   = w_accept ? w_is_div : r_md_div;
    assign bus.HILO_WE  = (r_state == S_DONE);
    assign bus.BUSY     = (r_state == S_BUSY);
endmodule

// File: tb/tb_alu_control_seq.sv
// Directed bench for alu_control_seq: decode table, mult/div sequencing, back-to-back,
// reset abort, and a second instance built with MULT_CYCLES = 1.
module tb_alu_control_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_control_seq_if #(.OP_W(4)) if0 ();
    alu_control_seq_if #(.OP_W(4)) if1 ();

    alu_control_seq #(.OP_W(4), .MULT_CYCLES(4), .DIV_CYCLES(8)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (if0.slave)
    );

    alu_control_seq #(.OP_W(4), .MULT_CYCLES(1), .DIV_CYCLES(8)) dut1 (
        .CLK (clk),
        .RST (rst),
        .bus (if1.slave)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [2:0] a, input logic [5:0] f);
        if0.VALID = v; if0.ALUOP = a; if0.FUNCTION = f;
    endtask

    task automatic test_reset();
        logic [3:0] fl;
        rst = 1'b1;
        drive0(1'b1, 3'b010, 6'b011000);
        if1.VALID = 1'b0; if1.ALUOP = 3'b000; if1.FUNCTION = 6'b000000;
        step(); step();
        @(negedge clk);
        fl = {if0.MD_START, if0.STALL, if0.BUSY, if0.HILO_WE};
        checks++;
        if (fl !== 4'b0000) begin
            failures++;
            $display("FAIL reset_hold flags=%b expected 0000", fl);
        end
        step();
        rst = 1'b0;
        drive0(1'b0, 3'b000, 6'b000000);
        @(negedge clk);
        fl = {if0.MD_START, if0.STALL, if0.BUSY, if0.HILO_WE};
        checks++;
        if ({fl, if0.OP, if0.ILLEGAL, if0.MD_DIV} !== {4'b0000, 4'd0, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_release flags=%b OP=%0d ILLEGAL=%b MD_DIV=%b expected 0000/0/0/0",
                     fl, if0.OP, if0.ILLEGAL, if0.MD_DIV);
        end
        $display("reset: done");
    endtask

    task automatic test_decode();
        logic [5:0] fn_tab [9] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                                   6'b100110, 6'b010000, 6'b011000, 6'b011010};
        logic [2:0] ao_tab [5] = '{3'b000, 3'b001, 3'b011, 3'b100, 3'b101};
        for (int i = 0; i < 9; i++) begin
            step();
            drive0(1'b1, 3'b010, fn_tab[i]);
            @(negedge clk);
            checks++;
            if ({if0.OP, if0.ILLEGAL} !== {4'(i), 1'b0}) begin
                failures++;
                $display("FAIL decode_r[%0d] OP=%0d ILLEGAL=%b expected OP=%0d ILLEGAL=0",
                         i, if0.OP, if0.ILLEGAL, i);
            end
            $display("decode R funct=%b OP=%0d", fn_tab[i], if0.OP);
            if (i >= 7) begin
                step();
                drive0(1'b0, 3'b000, 6'b000000);
                repeat ((i == 7) ? 5 : 9) step();
                @(negedge clk);
                checks++;
                if ({if0.BUSY, if0.HILO_WE} !== 2'b00) begin
                    failures++;
                    $display("FAIL decode_drain[%0d] BUSY=%b HILO_WE=%b expected 0 0",
                             i, if0.BUSY, if0.HILO_WE);
                end
            end
        end
        for (int i = 0; i < 5; i++) begin
            step();
            drive0(1'b1, ao_tab[i], 6'b111111);
            @(negedge clk);
            checks++;
            if ({if0.OP, if0.ILLEGAL, if0.STALL} !== {4'(i), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL decode_aluop[%b] OP=%0d ILLEGAL=%b STALL=%b expected OP=%0d 0 0",
                         ao_tab[i], if0.OP, if0.ILLEGAL, if0.STALL, i);
            end
            $display("decode ALUOP=%b OP=%0d", ao_tab[i], if0.OP);
        end
    endtask

    task automatic test_illegal();
        step();
        drive0(1'b1, 3'b010, 6'b111111);
        @(negedge clk);
        checks++;
        if ({if0.OP, if0.ILLEGAL} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_valid OP=%0d ILLEGAL=%b expected 0 1", if0.OP, if0.ILLEGAL);
        end
        step();
        drive0(1'b0, 3'b010, 6'b111111);
        @(negedge clk);
        checks++;
        if ({if0.OP, if0.ILLEGAL} !== {4'd0, 1'b0}) begin
            failures++;
            $display("FAIL illegal_novalid OP=%0d ILLEGAL=%b expected 0 0", if0.OP, if0.ILLEGAL);
        end
        step();
        drive0(1'b1, 3'b111, 6'b100000);
        @(negedge clk);
        checks++;
        if ({if0.OP, if0.ILLEGAL} !== {4'd0, 1'b1}) begin
            failures++;
            $display("FAIL illegal_aluop111 OP=%0d ILLEGAL=%b expected 0 1", if0.OP, if0.ILLEGAL);
        end
        step();
        drive0(1'b0, 3'b000, 6'b000000);
        $display("illegal: done");
    endtask

    task automatic test_mult();
        logic [3:0] fl, ex;
        for (int k = 0; k <= 6; k++) begin
            step();
            if (k == 0) drive0(1'b1, 3'b010, 6'b011000);
            else        drive0(1'b0, 3'b000, 6'b000000);
            @(negedge clk);
            fl = {if0.MD_START, if0.STALL, if0.BUSY, if0.HILO_WE};
            ex = {(k == 0), (k <= 4), (k >= 1 && k <= 4), (k == 5)};
            checks++;
            if (fl !== ex) begin
                failures++;
                $display("FAIL mult_flags[k=%0d] start/stall/busy/hilo=%b expected %b", k, fl, ex);
            end
            if (k <= 4) begin
                checks++;
                if ({if0.OP, if0.MD_DIV} !== {4'd7, 1'b0}) begin
                    failures++;
                    $display("FAIL mult_op[k=%0d] OP=%0d MD_DIV=%b expected 7 0", k, if0.OP, if0.MD_DIV);
                end
            end
        end
        $display("mult: sequence checked");
    endtask

    task automatic test_back_to_back();
        logic [3:0] fl, ex;
        for (int k = 0; k <= 19; k++) begin
            step();
            if (k == 0 || k == 9) drive0(1'b1, 3'b010, 6'b011010);
            else if (k <= 17)     drive0(1'b1, 3'b010, 6'b011000);
            else                  drive0(1'b0, 3'b000, 6'b000000);
            @(negedge clk);
            fl = {if0.MD_START, if0.STALL, if0.BUSY, if0.HILO_WE};
            ex = {(k == 0 || k == 9), (k <= 17),
                  ((k >= 1 && k <= 8) || (k >= 10 && k <= 17)), (k == 9 || k == 18)};
            checks++;
            if (fl !== ex) begin
                failures++;
                $display("FAIL b2b_flags[k=%0d] start/stall/busy/hilo=%b expected %b", k, fl, ex);
            end
            if (k <= 17) begin
                checks++;
                if ({if0.OP, if0.MD_DIV, if0.ILLEGAL} !== {4'd8, 1'b1, 1'b0}) begin
                    failures++;
                    $display("FAIL b2b_op[k=%0d] OP=%0d MD_DIV=%b ILLEGAL=%b expected 8 1 0",
                             k, if0.OP, if0.MD_DIV, if0.ILLEGAL);
                end
            end
        end
        $display("back_to_back: two divs checked");
    endtask

    task automatic test_reset_abort();
        logic [3:0] fl, ex;
        for (int k = 0; k <= 8; k++) begin
            step();
            rst = (k == 2);
            if (k == 0 || k == 2) drive0(1'b1, 3'b010, 6'b011000);
            else                  drive0(1'b0, 3'b000, 6'b000000);
            @(negedge clk);
            fl = {if0.MD_START, if0.STALL, if0.BUSY, if0.HILO_WE};
            ex = (k == 0) ? 4'b1100 : (k == 1) ? 4'b0110 : (k == 2) ? 4'b0010 : 4'b0000;
            checks++;
            if (fl !== ex) begin
                failures++;
                $display("FAIL abort_flags[k=%0d] start/stall/busy/hilo=%b expected %b", k, fl, ex);
            end
            if (k == 3) begin
                checks++;
                if ({if0.OP, if0.MD_DIV} !== {4'd0, 1'b0}) begin
                    failures++;
                    $display("FAIL abort_cleared OP=%0d MD_DIV=%b expected 0 0", if0.OP, if0.MD_DIV);
                end
            end
        end
        rst = 1'b0;
        $display("reset_abort: done");
    endtask

    task automatic test_mult_one_cycle();
        logic [3:0] fl, ex;
        for (int k = 0; k <= 3; k++) begin
            step();
            if1.VALID    = (k == 0);
            if1.ALUOP    = 3'b010;
            if1.FUNCTION = 6'b011000;
            @(negedge clk);
            fl = {if1.MD_START, if1.STALL, if1.BUSY, if1.HILO_WE};
            ex = {(k == 0), (k <= 1), (k == 1), (k == 2)};
            checks++;
            if (fl !== ex) begin
                failures++;
                $display("FAIL mult1_flags[k=%0d] start/stall/busy/hilo=%b expected %b", k, fl, ex);
            end
        end
        if1.VALID = 1'b0;
        $display("mult_one_cycle: done");
    endtask

    initial begin
        drive0(1'b0, 3'b000, 6'b000000);
        if1.VALID = 1'b0; if1.ALUOP = 3'b000; if1.FUNCTION = 6'b000000;
        test_reset();
        test_decode();
        test_illegal();
        test_mult();
        test_back_to_back();
        test_reset_abort();
        test_mult_one_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
